// File: rtl/mem_access_ctrl.sv
// Load/store front end for data_mem: word loads/stores, byte loads with lane select and
// sign/zero extension, and byte stores through read-modify-write (data_mem has no byte enables).
module mem_access_ctrl #(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16,
  parameter bit          ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              memr,
  output logic              memw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] mdr
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned EXT_W  = DATA_W - BYTE_W;

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP
  } state_t;

  state_t              state, state_nxt;
  logic                req_ready_nxt, resp_valid_nxt, resp_err_nxt, memr_nxt, memw_nxt;
  logic [DATA_W-1:0]   resp_rdata_nxt, data_in_nxt;
  logic [ADDR_W-1:0]   addr_nxt;

  // Request fields still needed after the accept edge
  logic                lat_byte, lat_signed, lat_lane;
  logic [BYTE_W-1:0]   lat_wbyte;
  logic                lat_byte_nxt, lat_signed_nxt, lat_lane_nxt;
  logic [BYTE_W-1:0]   lat_wbyte_nxt;

  logic                misaligned;
  logic [BYTE_W-1:0]   lane_byte;
  logic [DATA_W-1:0]   load_data, merged_word;

  assign misaligned = ERR_ON_MISALIGN && !req_byte && req_addr[0];

  // Lane 1 is the odd bank, carried in the upper half of the word
  assign lane_byte = lat_lane ? mdr[DATA_W-1:BYTE_W] : mdr[BYTE_W-1:0];

  always_comb begin
    load_data = mdr;
    if (lat_byte) begin
      if (lat_signed) load_data = {{EXT_W{lane_byte[BYTE_W-1]}}, lane_byte};
      else            load_data = {EXT_W'(0), lane_byte};
    end
  end

  assign merged_word = lat_lane ? {lat_wbyte, mdr[BYTE_W-1:0]}
                                : {mdr[DATA_W-1:BYTE_W], lat_wbyte};

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    data_in_nxt    = '0;
    resp_rdata_nxt = resp_rdata;
    resp_err_nxt   = resp_err;
    lat_byte_nxt   = lat_byte;
    lat_signed_nxt = lat_signed;
    lat_lane_nxt   = lat_lane;
    lat_wbyte_nxt  = lat_wbyte;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_nxt       = {req_addr[ADDR_W-1:1], 1'b0};
          lat_byte_nxt   = req_byte;
          lat_signed_nxt = req_signed;
          lat_lane_nxt   = req_addr[0];
          lat_wbyte_nxt  = req_wdata[BYTE_W-1:0];
          if (misaligned) begin
            state_nxt      = RESP;
            resp_err_nxt   = 1'b1;
            resp_rdata_nxt = '0;
          end else if (!req_write) begin
            state_nxt = RD;
          end else if (!req_byte) begin
            state_nxt   = WR;
            data_in_nxt = req_wdata;
          end else begin
            state_nxt = RMW_RD;
          end
        end
      end
      RD:       state_nxt = RD_WAIT;
      RD_WAIT: begin
        state_nxt      = RESP;
        resp_rdata_nxt = load_data;
        resp_err_nxt   = 1'b0;
      end
      WR: begin
        state_nxt      = RESP;
        resp_rdata_nxt = '0;
        resp_err_nxt   = 1'b0;
      end
      RMW_RD:   state_nxt = RMW_WAIT;
      RMW_WAIT: begin
        state_nxt   = RMW_WR;
        data_in_nxt = merged_word;
      end
      RMW_WR: begin
        state_nxt      = RESP;
        resp_rdata_nxt = '0;
        resp_err_nxt   = 1'b0;
      end
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    req_ready_nxt  = (state_nxt == IDLE);
    resp_valid_nxt = (state_nxt == RESP);
    memr_nxt       = (state_nxt == RD) || (state_nxt == RMW_RD);
    memw_nxt       = (state_nxt == WR) || (state_nxt == RMW_WR);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      memr       <= 1'b0;
      memw       <= 1'b0;
      addr       <= '0;
      data_in    <= '0;
      lat_byte   <= 1'b0;
      lat_signed <= 1'b0;
      lat_lane   <= 1'b0;
      lat_wbyte  <= '0;
    end else begin
      state      <= state_nxt;
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      resp_err   <= resp_err_nxt;
      memr       <= memr_nxt;
      memw       <= memw_nxt;
      addr       <= addr_nxt;
      data_in    <= data_in_nxt;
      lat_byte   <= lat_byte_nxt;
      lat_signed <= lat_signed_nxt;
      lat_lane   <= lat_lane_nxt;
      lat_wbyte  <= lat_wbyte_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic against a byte-addressed
// reference memory; dut1 is built with ERR_ON_MISALIGN=0.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid0, req_valid1, req_write, req_byte, req_signed;
  logic [15:0] req_addr, req_wdata;

  logic        ready0, resp_valid0, resp_err0, memr0, memw0;
  logic [15:0] resp_rdata0, addr0, data_in0, mdr0;
  logic        ready1, resp_valid1, resp_err1, memr1, memw1;
  logic [15:0] resp_rdata1, addr1, data_in1, mdr1;

  bit   [15:0] mem0 [0:32767];
  bit   [15:0] mem1 [0:32767];
  logic        bd_we0, bd_we1;
  logic [14:0] bd_idx;
  logic [15:0] bd_data;

  logic [7:0]  ref_mem [0:65535];

  int          nr0 = 0, nw0 = 0, nr1 = 0, nw1 = 0, vio0 = 0;
  logic [15:0] waddr0 = '0, wdat0 = '0, raddr1 = '0;
  int          n_pass = 0, n_total = 0;

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .ERR_ON_MISALIGN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(ready0),
    .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0), .memr(memr0), .memw(memw0),
    .addr(addr0), .data_in(data_in0), .mdr(mdr0));

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .ERR_ON_MISALIGN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(ready1),
    .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1), .memr(memr1), .memw(memw1),
    .addr(addr1), .data_in(data_in1), .mdr(mdr1));

  // data_mem models: synchronous write, registered read
  always @(posedge clk) begin
    if (bd_we0) mem0[bd_idx] <= bd_data;
    else if (memw0) mem0[addr0[15:1]] <= data_in0;
    if (memr0) mdr0 <= mem0[addr0[15:1]];
    if (bd_we1) mem1[bd_idx] <= bd_data;
    else if (memw1) mem1[addr1[15:1]] <= data_in1;
    if (memr1) mdr1 <= mem1[addr1[15:1]];
  end

  // Bus activity counters and protocol-rule violations
  always @(negedge clk) begin
    if (memr0) nr0 <= nr0 + 1;
    if (memw0) begin
      nw0 <= nw0 + 1; waddr0 <= addr0; wdat0 <= data_in0;
    end
    if ((memr0 && memw0) || ((memr0 || memw0) && (resp_valid0 || ready0)) ||
        (!memw0 && data_in0 != 16'h0) || (addr0[0] === 1'b1))
      vio0 <= vio0 + 1;
    if (memr1) begin nr1 <= nr1 + 1; raddr1 <= addr1; end
    if (memw1) nw1 <= nw1 + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  // Reference behaviour of dut0 over a byte-addressed memory
  function automatic void model(input bit w, input bit b, input bit s, input logic [15:0] a,
                                input logic [15:0] wd, output logic [15:0] rd,
                                output bit err, output int lat);
    logic [15:0] lo, hi;
    lo = {a[15:1], 1'b0};
    hi = {a[15:1], 1'b1};
    err = 1'b0;
    rd  = 16'h0;
    if (!b && a[0]) begin
      err = 1'b1; lat = 1;
    end else if (w && b) begin
      ref_mem[a] = wd[7:0]; lat = 4;
    end else if (w) begin
      ref_mem[lo] = wd[7:0]; ref_mem[hi] = wd[15:8]; lat = 2;
    end else begin
      lat = 3;
      if (!b)     rd = {ref_mem[hi], ref_mem[lo]};
      else if (s) rd = {{8{ref_mem[a][7]}}, ref_mem[a]};
      else        rd = {8'h00, ref_mem[a]};
    end
  endfunction

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    return {ref_mem[{a[15:1], 1'b1}], ref_mem[{a[15:1], 1'b0}]};
  endfunction

  task automatic preload(input bit sel, input logic [14:0] idx, input logic [15:0] v);
    @(negedge clk);
    bd_idx = idx; bd_data = v;
    if (sel) bd_we1 = 1'b1; else bd_we0 = 1'b1;
    @(negedge clk);
    bd_we0 = 1'b0; bd_we1 = 1'b0;
    if (!sel) begin
      ref_mem[{idx, 1'b0}] = v[7:0];
      ref_mem[{idx, 1'b1}] = v[15:8];
    end
  endtask

  task automatic run_txn(input bit sel, input bit w, input bit b, input bit s,
                         input logic [15:0] a, input logic [15:0] wd,
                         output int lat, output logic [15:0] rd, output bit err,
                         output int dr, output int dw);
    int n, r0, w0;
    @(negedge clk);
    req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = wd;
    if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    n = 0;
    while (!(sel ? ready1 : ready0) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      n_total++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, required high", n);
    end
    r0 = sel ? nr1 : nr0;
    w0 = sel ? nw1 : nw0;
    @(posedge clk);
    @(negedge clk);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    lat = 1;
    while (!(sel ? resp_valid1 : resp_valid0) && lat < 20) begin @(negedge clk); lat++; end
    rd  = sel ? resp_rdata1 : resp_rdata0;
    err = sel ? resp_err1 : resp_err0;
    dr  = (sel ? nr1 : nr0) - r0;
    dw  = (sel ? nw1 : nw0) - w0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid0 = 1'b0; req_valid1 = 1'b0; req_write = 1'b0; req_byte = 1'b0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    bd_we0 = 1'b0; bd_we1 = 1'b0; bd_idx = '0; bd_data = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({ready0, resp_valid0, resp_err0, memr0, memw0} !== 5'b10000)
      $display("FAIL reset_ctrl: {ready,valid,err,memr,memw}=%b, expected 10000",
               {ready0, resp_valid0, resp_err0, memr0, memw0});
    else n_pass++;
    n_total++;
    if ({addr0, data_in0, resp_rdata0} !== 48'h0)
      $display("FAIL reset_data: addr=%h data_in=%h rdata=%h, expected all 0",
               addr0, data_in0, resp_rdata0);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_word_store_load();
    int lat, dr, dw, el; logic [15:0] rd, erd; bit err, eerr;
    model(1'b1, 1'b0, 1'b0, 16'h2340, 16'hABCD, erd, eerr, el);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h2340, 16'hABCD, lat, rd, err, dr, dw);
    n_total++;
    if (lat !== 2 || dw !== 1 || dr !== 0)
      $display("FAIL wstore_timing: lat=%0d memw=%0d memr=%0d, expected 2/1/0", lat, dw, dr);
    else n_pass++;
    n_total++;
    if (waddr0 !== 16'h2340 || wdat0 !== 16'hABCD)
      $display("FAIL wstore_bus: addr=%h data_in=%h, expected 2340/abcd", waddr0, wdat0);
    else n_pass++;
    model(1'b0, 1'b0, 1'b0, 16'h2340, 16'h0, erd, eerr, el);
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h2340, 16'h0, lat, rd, err, dr, dw);
    n_total++;
    if (lat !== 3 || rd !== 16'hABCD || err !== 1'b0 || dr !== 1)
      $display("FAIL wload: lat=%0d rdata=%h err=%b memr=%0d, expected 3/abcd/0/1",
               lat, rd, err, dr);
    else n_pass++;
  endtask

  task automatic test_byte_store();
    int lat, dr, dw, el; logic [15:0] rd, erd; bit err, eerr;
    model(1'b1, 1'b1, 1'b0, 16'h2341, 16'hFF5A, erd, eerr, el);
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 16'h2341, 16'hFF5A, lat, rd, err, dr, dw);
    n_total++;
    if (lat !== 4 || dr !== 1 || dw !== 1 || rd !== 16'h0)
      $display("FAIL bstore_timing: lat=%0d memr=%0d memw=%0d rdata=%h, expected 4/1/1/0000",
               lat, dr, dw, rd);
    else n_pass++;
    n_total++;
    if (waddr0 !== 16'h2340 || wdat0 !== 16'h5ACD)
      $display("FAIL bstore_merge: addr=%h data_in=%h, expected 2340/5acd", waddr0, wdat0);
    else n_pass++;
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h2340, 16'h0, lat, rd, err, dr, dw);
    n_total++;
    if (rd !== 16'h5ACD)
      $display("FAIL bstore_readback: rdata=%h, expected 5acd", rd);
    else n_pass++;
  endtask

  task automatic test_byte_load();
    int lat, dr, dw;
    logic [15:0] rd;
    bit err;
    logic [15:0] addrs [4];
    bit          sgn   [4];
    logic [15:0] exp   [4];
    addrs = '{16'h2341, 16'h2341, 16'h2340, 16'h2340};
    sgn   = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp   = '{16'h005A, 16'h005A, 16'hFFCD, 16'h00CD};
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, 1'b0, 1'b1, sgn[i], addrs[i], 16'h0, lat, rd, err, dr, dw);
      n_total++;
      if (rd !== exp[i] || lat !== 3 || err !== 1'b0)
        $display("FAIL bload_%0d: rdata=%h lat=%0d err=%b, expected %h/3/0",
                 i, rd, lat, err, exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_misalign();
    int lat, dr, dw; logic [15:0] rd; bit err;
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h2341, 16'h0, lat, rd, err, dr, dw);
    n_total++;
    if (err !== 1'b1 || rd !== 16'h0 || lat !== 1 || dr !== 0 || dw !== 0)
      $display("FAIL misalign_err: err=%b rdata=%h lat=%0d memr=%0d memw=%0d, expected 1/0000/1/0/0",
               err, rd, lat, dr, dw);
    else n_pass++;
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h1234, lat, rd, err, dr, dw);
    n_total++;
    if (err !== 1'b1 || lat !== 1 || dw !== 0)
      $display("FAIL misalign_store: err=%b lat=%0d memw=%0d, expected 1/1/0", err, lat, dw);
    else n_pass++;
    preload(1'b1, 15'h11A0, 16'h5ACD);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h2341, 16'h0, lat, rd, err, dr, dw);
    n_total++;
    if (rd !== 16'h5ACD || err !== 1'b0 || lat !== 3 || dr !== 1 || raddr1 !== 16'h2340)
      $display("FAIL misalign_forced: rdata=%h err=%b lat=%0d memr=%0d addr=%h, expected 5acd/0/3/1/2340",
               rd, err, lat, dr, raddr1);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] d, erd; bit eerr; int el, cyc, ready_cyc, lat; bit seen;
    d = 16'($urandom);
    model(1'b1, 1'b0, 1'b0, 16'h2342, d, erd, eerr, el);
    @(negedge clk);
    req_write = 1'b1; req_byte = 1'b0; req_signed = 1'b0; req_addr = 16'h2342; req_wdata = d;
    req_valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b0; req_addr = 16'h2342; req_wdata = ~d;
    cyc = 1; seen = 1'b0; ready_cyc = 0;
    while (cyc < 20) begin
      if (resp_valid0) seen = 1'b1;
      if (ready0) begin ready_cyc = cyc; break; end
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (ready_cyc !== 3 || seen !== 1'b1)
      $display("FAIL b2b_accept: ready at cycle %0d resp_seen=%b, expected 3/1", ready_cyc, seen);
    else n_pass++;
    model(1'b0, 1'b0, 1'b0, 16'h2342, 16'h0, erd, eerr, el);
    @(posedge clk);
    @(negedge clk);
    req_valid0 = 1'b0;
    lat = 1;
    while (!resp_valid0 && lat < 20) begin @(negedge clk); lat++; end
    n_total++;
    if (resp_rdata0 !== erd || lat !== 3)
      $display("FAIL b2b_second: rdata=%h lat=%0d, expected %h/3", resp_rdata0, lat, erd);
    else n_pass++;
  endtask

  task automatic test_reset_mid_rmw();
    logic [15:0] old, rd; int w0, lat, dr, dw; bit seen, err;
    old = ref_word(16'h2344);
    w0  = nw0;
    @(negedge clk);
    req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0; req_addr = 16'h2345;
    req_wdata = ~old;
    req_valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({ready0, resp_valid0, resp_err0, memr0, memw0} !== 5'b10000 ||
        {addr0, data_in0, resp_rdata0} !== 48'h0)
      $display("FAIL midrst_outputs: ctrl=%b addr=%h data_in=%h rdata=%h, expected 10000 and zeros",
               {ready0, resp_valid0, resp_err0, memr0, memw0}, addr0, data_in0, resp_rdata0);
    else n_pass++;
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid0) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0 || nw0 - w0 !== 0)
      $display("FAIL midrst_silent: resp_seen=%b memw=%0d, expected 0/0", seen, nw0 - w0);
    else n_pass++;
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 16'h2344, 16'h0, lat, rd, err, dr, dw);
    n_total++;
    if (rd !== old)
      $display("FAIL midrst_mem: word=%h, expected unchanged %h", rd, old);
    else n_pass++;
  endtask

  task automatic test_random();
    bit w, b, s, err, eerr;
    logic [15:0] a, wd, rd, erd;
    int lat, el, dr, dw;
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      wd = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'hFFFE | 16'($urandom_range(0, 1));
      else                           a = 16'h2340 + 16'($urandom_range(0, 31));
      model(w, b, s, a, wd, erd, eerr, el);
      run_txn(1'b0, w, b, s, a, wd, lat, rd, err, dr, dw);
      n_total++;
      if (lat !== el || rd !== erd || err !== eerr)
        $display("FAIL rand_%0d resp: w=%b b=%b s=%b a=%h lat=%0d rdata=%h err=%b, expected %0d/%h/%b",
                 i, w, b, s, a, lat, rd, err, el, erd, eerr);
      else n_pass++;
      n_total++;
      if (dr !== ((!eerr && (!w || b)) ? 1 : 0) || dw !== ((!eerr && w) ? 1 : 0))
        $display("FAIL rand_%0d bus: memr=%0d memw=%0d for w=%b b=%b err=%b", i, dr, dw, w, b, eerr);
      else n_pass++;
      if (w && !eerr) begin
        n_total++;
        if (waddr0 !== {a[15:1], 1'b0} || wdat0 !== ref_word(a))
          $display("FAIL rand_%0d wdata: addr=%h data_in=%h, expected %h/%h",
                   i, waddr0, wdat0, {a[15:1], 1'b0}, ref_word(a));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 16; i++) preload(1'b0, 15'h11A0 + 15'(i), 16'($urandom));
    preload(1'b0, 15'h7FFF, 16'($urandom));
    test_word_store_load();
    test_byte_store();
    test_byte_load();
    test_misalign();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    n_total++;
    if (vio0 !== 0)
      $display("FAIL bus_rules: %0d cycles broke memr/memw/data_in/addr rules, expected 0", vio0);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
